delay_line_ctrl: RTL and testbench

- Sequencer for the echo/delay effect's circular sample RAM.
- Accepts one audio sample per handshake and reads the sample D positions back.
- Writes the new sample, then presents the delayed sample to the downstream mixer.
- Owns the write pointer, read-address arithmetic, fill tracking and delay-length decode from the effect `options` word.

---
 rtl/delay_pkg.sv | 26 ++
 rtl/delay_line_ctrl_if.sv | 32 +++
 rtl/delay_ptr_gen.sv | 49 ++++
 rtl/delay_line_ctrl.sv | 141 ++++++++++++++
 tb/tb_delay_line_ctrl.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/delay_pkg.sv
// Shared definitions for the delay-line controller.
//   state_t       sequencer states (IDLE, READ, CAPT, WRITE)
//   fill_width()  width of the fill counter for a given address width
//                 (one extra bit so it can hold the value SIZE)
//   decode_delay() options word -> delay length D, saturating at SIZE
package delay_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    CAPT  = 2'd2,
    WRITE = 2'd3
  } state_t;

  function automatic int fill_width(input int addr_width);
    return addr_width + 1;
  endfunction

  // D = min(options + 1, size); options = 0 is the shortest delay (1).
  function automatic int decode_delay(input logic [3:0] options, input int size);
    int d;
    d = int'(options) + 1;
    return (d > size) ? size : d;
  endfunction

endpackage

// File: rtl/delay_line_ctrl_if.sv
// Bus bundle between the delay-line controller and its environment.
//   in_valid/in_ready/in_data     sample input handshake
//   out_valid/out_data            delayed sample to the mixer (no back-pressure)
//   ram_addr/ram_we/ram_wdata     sample RAM command
//   ram_rdata                     sample RAM read data (registered, 1-cycle)
// master: the controller side.  slave: the source/mixer/RAM side.
interface delay_line_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  modport master (
    input  in_valid, in_data, ram_rdata,
    output in_ready, out_valid, out_data, ram_addr, ram_we, ram_wdata
  );

  modport slave (
    output in_valid, in_data, ram_rdata,
    input  in_ready, out_valid, out_data, ram_addr, ram_we, ram_wdata
  );

endinterface

// File: rtl/delay_ptr_gen.sv
// Write-pointer / fill-count bookkeeping for the circular sample RAM.
//   clk        rising-edge clock
//   rst        synchronous active-low clear
//   advance    one-cycle strobe: a sample has just been written
//   delay_mod  delay length D modulo SIZE (low ADDR_WIDTH bits of D)
//   wr_ptr     next write address
//   fill_cnt   samples written so far, saturating at SIZE
//   rd_addr    wr_ptr - D with natural ADDR_WIDTH wrap
module delay_ptr_gen
  import delay_pkg::*;
#(
  parameter int ADDR_WIDTH = 3,
  parameter int SIZE       = 8,
  parameter int FILL_WIDTH = fill_width(ADDR_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  advance,
  input  logic [ADDR_WIDTH-1:0] delay_mod,
  output logic [ADDR_WIDTH-1:0] wr_ptr,
  output logic [FILL_WIDTH-1:0] fill_cnt,
  output logic [ADDR_WIDTH-1:0] rd_addr
);

  localparam logic [FILL_WIDTH-1:0] FULL = FILL_WIDTH'(SIZE);

  logic [ADDR_WIDTH-1:0] wr_ptr_reg;
  logic [FILL_WIDTH-1:0] fill_cnt_reg;

  // SIZE is a power of two, so the pointer wraps SIZE-1 -> 0 by overflow.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg   <= '0;
      fill_cnt_reg <= '0;
    end else if (advance) begin
      wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (fill_cnt_reg < FULL) begin
        fill_cnt_reg <= fill_cnt_reg + 1'b1;
      end
    end
  end

  // D = SIZE reduces to 0 here, so the read lands on the slot about to be
  // overwritten, which still holds the sample from SIZE writes ago.
  assign rd_addr  = wr_ptr_reg - delay_mod;
  assign wr_ptr   = wr_ptr_reg;
  assign fill_cnt = fill_cnt_reg;

endmodule

// File: rtl/delay_line_ctrl.sv
// Echo/delay sequencer around a circular sample RAM.
//   CLK      rising-edge clock
//   rst      synchronous active-low reset; all outputs forced to 0 while low
//   en       1 = delay active, 0 = bypass (sampled at accept only)
//   options  delay-length select, D = min(options+1, SIZE), latched at accept
//   bus      master side of delay_line_ctrl_if (input handshake, output
//            pulse, RAM command/read data)
// Per accepted sample (en=1): READ the slot D back, CAPT the registered RAM
// data, WRITE the new sample, then pulse out_valid. Before D samples have
// been written the delayed output is 0. SIZE must equal 2**ADDR_WIDTH.
module delay_line_ctrl
  import delay_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SIZE       = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             en,
  input  logic [3:0]       options,
  delay_line_ctrl_if.master bus
);

  localparam int FW = fill_width(ADDR_WIDTH);

  state_t                state_reg;
  state_t                state_next;

  logic [FW-1:0]         delay_decoded;
  logic [FW-1:0]         delay_reg;
  logic [DATA_WIDTH-1:0] sample_reg;
  logic [DATA_WIDTH-1:0] out_data_reg;
  logic                  out_valid_reg;

  logic                  accept;
  logic                  advance;
  logic                  capture;
  logic                  ram_we_next;
  logic [ADDR_WIDTH-1:0] ram_addr_next;

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [FW-1:0]         fill_cnt;

  assign delay_decoded = FW'(decode_delay(options, SIZE));

  // in_ready is gated by rst so nothing is offered while reset is held.
  assign accept = rst && (state_reg == IDLE) && bus.in_valid;

  delay_ptr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .SIZE       (SIZE),
    .FILL_WIDTH (FW)
  ) u_ptr (
    .clk       (CLK),
    .rst       (rst),
    .advance   (advance),
    .delay_mod (delay_reg[ADDR_WIDTH-1:0]),
    .wr_ptr    (wr_ptr),
    .fill_cnt  (fill_cnt),
    .rd_addr   (rd_addr)
  );

  always_ff @(posedge CLK) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Bypass never leaves IDLE; only the delay path walks the RAM sequence.
  always_comb begin
    state_next    = state_reg;
    ram_addr_next = wr_ptr;
    ram_we_next   = 1'b0;
    advance       = 1'b0;
    capture       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept && en) begin
          state_next = READ;
        end
      end
      READ: begin
        ram_addr_next = rd_addr;
        state_next    = CAPT;
      end
      CAPT: begin
        // Address held steady while the registered read data is consumed.
        ram_addr_next = rd_addr;
        capture       = 1'b1;
        state_next    = WRITE;
      end
      WRITE: begin
        ram_addr_next = wr_ptr;
        ram_we_next   = 1'b1;
        advance       = 1'b1;
        state_next    = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!rst) begin
      delay_reg     <= '0;
      sample_reg    <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= 1'b0;
      if (accept) begin
        sample_reg <= bus.in_data;
        delay_reg  <= delay_decoded;
      end
      if (accept && !en) begin
        out_data_reg  <= bus.in_data;
        out_valid_reg <= 1'b1;
      end
      // fill_cnt still excludes the current sample, which is written later.
      if (capture) begin
        out_data_reg <= (fill_cnt >= delay_reg) ? bus.ram_rdata : '0;
      end
      if (advance) begin
        out_valid_reg <= 1'b1;
      end
    end
  end

  assign bus.in_ready  = rst && (state_reg == IDLE);
  assign bus.out_valid = rst && out_valid_reg;
  assign bus.out_data  = rst ? out_data_reg : '0;
  assign bus.ram_we    = rst && ram_we_next;
  assign bus.ram_addr  = rst ? ram_addr_next : '0;
  assign bus.ram_wdata = rst ? sample_reg : '0;

endmodule

// File: tb/tb_delay_line_ctrl.sv
module tb_delay_line_ctrl;

  logic       CLK = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] options;

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_wptr = 3'd0;

  delay_line_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) bus ();

  delay_line_ctrl #(.DATA_WIDTH(32), .SIZE(8), .ADDR_WIDTH(3)) dut (
    .CLK     (CLK),
    .rst     (rst),
    .en      (en),
    .options (options),
    .bus     (bus)
  );

  always #5 CLK = ~CLK;

  // Sample RAM: registered read, read-before-write within a cycle.
  logic [31:0] mem [8];
  always_ff @(posedge CLK) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  typedef struct {
    logic        rst_before;
    logic        en;
    logic [3:0]  opt;
    logic [31:0] x;
    logic [31:0] y;
  } vec_t;

  vec_t tbl [37];

  function automatic vec_t mk(input logic r, input logic e, input logic [3:0] o,
                              input logic [31:0] x, input logic [31:0] y);
    vec_t v;
    v.rst_before = r; v.en = e; v.opt = o; v.x = x; v.y = y;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", bus.out_data, 32'd0);
    chk("rst_ram_we", 32'(bus.ram_we), 32'd0);
    chk("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
    chk("rst_ram_wdata", bus.ram_wdata, 32'd0);
    rst = 1'b1;
    @(negedge CLK);
    chk("rel_in_ready", 32'(bus.in_ready), 32'd1);
    exp_wptr = 3'd0;
  endtask

  task automatic send(input vec_t v);
    int          wait_cyc;
    int          lat;
    int          pulses;
    int          we_cnt;
    int          d;
    logic [31:0] y;
    logic [2:0]  exp_rd;
    wait_cyc = 0;
    while (bus.in_ready !== 1'b1 && wait_cyc < 20) begin
      @(negedge CLK);
      wait_cyc++;
    end
    chk("ready_wait", 32'(bus.in_ready), 32'd1);
    d = (v.opt >= 4'd7) ? 8 : int'(v.opt) + 1;
    exp_rd = 3'(int'(exp_wptr) - d);
    en = v.en;
    options = v.opt;
    bus.in_valid = 1'b1;
    bus.in_data = v.x;
    @(posedge CLK);
    #1;
    // Disturb the sampled controls: neither may affect this transaction.
    bus.in_valid = 1'b0;
    options = ~v.opt;
    en = ~v.en;
    lat = -1; pulses = 0; we_cnt = 0; y = 32'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      if (bus.out_valid) begin
        pulses++;
        if (lat < 0) lat = i;
        y = bus.out_data;
      end
      if (bus.ram_we) we_cnt++;
      if (v.en) begin
        if (i == 0) chk("rd_addr", 32'(bus.ram_addr), 32'(exp_rd));
        if (i == 2) begin
          chk("wr_addr", 32'(bus.ram_addr), 32'(exp_wptr));
          chk("wdata", bus.ram_wdata, v.x);
        end
        if (i < 3) chk("busy_ready", 32'(bus.in_ready), 32'd0);
      end
    end
    chk("latency", 32'(lat), v.en ? 32'd3 : 32'd0);
    chk("pulses", 32'(pulses), 32'd1);
    chk("we_cnt", 32'(we_cnt), v.en ? 32'd1 : 32'd0);
    chk("y", y, v.y);
    if (v.en) exp_wptr = exp_wptr + 3'd1;
    chk("idle_addr", 32'(bus.ram_addr), 32'(exp_wptr));
    $display("TXN en=%b opt=%0d x=%h y=%h exp=%h lat=%0d", v.en, v.opt, v.x, y, v.y, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int accepts;
    int bad;
    rst = 1'b0;
    en = 1'b1;
    options = 4'd0;
    bus.in_valid = 1'b0;
    bus.in_data = 32'd0;

    // Test 1: D=3
    tbl[0] = mk(1'b1, 1'b1, 4'd2, 32'd1, 32'd0);
    tbl[1] = mk(1'b0, 1'b1, 4'd2, 32'd2, 32'd0);
    tbl[2] = mk(1'b0, 1'b1, 4'd2, 32'd3, 32'd0);
    tbl[3] = mk(1'b0, 1'b1, 4'd2, 32'd4, 32'd1);
    tbl[4] = mk(1'b0, 1'b1, 4'd2, 32'd5, 32'd2);
    // Test 2: D=8, eight zeros then 1,2 (9th write wraps to address 0)
    for (int k = 1; k <= 10; k++)
      tbl[4 + k] = mk(k == 1, 1'b1, 4'b1000, 32'(k), (k <= 8) ? 32'd0 : 32'(k - 8));
    // Test 3: D=1, y = k-1 after the first
    for (int k = 1; k <= 20; k++)
      tbl[14 + k] = mk(k == 1, 1'b1, 4'd0, 32'(k), (k == 1) ? 32'd0 : 32'(k - 1));
    // Test 4: bypass, then confirm pointer and fill were frozen
    tbl[35] = mk(1'b0, 1'b0, 4'd0, 32'hDEADBEEF, 32'hDEADBEEF);
    tbl[36] = mk(1'b0, 1'b1, 4'd0, 32'd21, 32'd20);

    for (n = 0; n < 37; n++) begin
      if (tbl[n].rst_before) do_reset();
      send(tbl[n]);
    end

    // Test 5: in_valid held high for 40 cycles
    en = 1'b1;
    options = 4'd0;
    bus.in_valid = 1'b1;
    accepts = 0;
    bad = 0;
    for (int j = 0; j < 40; j++) begin
      if (bus.in_ready) accepts++;
      if (bus.in_ready !== ((j % 4) == 0)) bad++;
      bus.in_data = 32'(j + 100);
      @(negedge CLK);
    end
    bus.in_valid = 1'b0;
    chk("stream_accepts", 32'(accepts), 32'd10);
    chk("stream_ready_pattern", 32'(bad), 32'd0);
    $display("TXN stream accepts=%0d ready_mismatch=%0d", accepts, bad);
    exp_wptr = exp_wptr + 3'd2;  // 10 writes mod 8
    repeat (4) @(negedge CLK);
    chk("stream_idle_addr", 32'(bus.ram_addr), 32'(exp_wptr));

    // Test 6: reset asserted during WRITE
    do_reset();
    send(mk(1'b0, 1'b1, 4'd0, 32'd11, 32'd0));
    send(mk(1'b0, 1'b1, 4'd0, 32'd12, 32'd11));
    en = 1'b1;
    options = 4'd0;
    bus.in_valid = 1'b1;
    bus.in_data = 32'd99;
    @(posedge CLK);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(negedge CLK);
    chk("abort_in_write", 32'(bus.ram_we), 32'd1);
    rst = 1'b0;
    @(negedge CLK);
    chk("abort_we", 32'(bus.ram_we), 32'd0);
    chk("abort_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_ready", 32'(bus.in_ready), 32'd0);
    @(negedge CLK);
    chk("abort_valid2", 32'(bus.out_valid), 32'd0);
    rst = 1'b1;
    @(negedge CLK);
    chk("abort_rel_ready", 32'(bus.in_ready), 32'd1);
    chk("abort_wptr", 32'(bus.ram_addr), 32'd0);
    chk("abort_no_valid", 32'(bus.out_valid), 32'd0);
    $display("TXN reset-abort during WRITE");
    exp_wptr = 3'd0;
    send(mk(1'b0, 1'b1, 4'd0, 32'd5, 32'd0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
